// File: rtl/instruction_fetch_pkg.sv
// Shared core definitions for the fetch stage: sequencer states, reset PC and alignment helper.
package instruction_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        WAIT_PC = 2'd2,
        FAULT   = 2'd3
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: one outstanding memory read, single-entry instruction hold,
// redirect handling with response kill, and a sticky misaligned-PC fault.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] next_pc,
    input  logic        pc_load,
    output logic [31:0] pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        misaligned
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  addr_q, addr_d;
    logic         kill_q, kill_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  instr_pc_q, instr_pc_d;
    logic         valid_q, valid_d;
    logic         mis_q, mis_d;

    logic         load_ok_s;
    logic         load_bad_s;

    assign load_ok_s  = pc_load & is_word_aligned(next_pc);
    assign load_bad_s = pc_load & ~is_word_aligned(next_pc);

    // Next-state and datapath decisions for the fetch sequencer.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        kill_d     = kill_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        mis_d      = mis_q;

        case (state_q)
            FETCH: begin
                if (load_bad_s) begin
                    state_d = FAULT;
                    mis_d   = 1'b1;
                    kill_d  = 1'b0;
                end else if (load_ok_s) begin
                    // A redirect with the ack in hand re-issues at once; otherwise the
                    // in-flight read is left to finish on its old address and is dropped.
                    pc_d = next_pc;
                    if (imem_ack) begin
                        addr_d = next_pc;
                        kill_d = 1'b0;
                    end else begin
                        kill_d = 1'b1;
                    end
                end else if (imem_ack) begin
                    if (kill_q) begin
                        kill_d = 1'b0;
                        addr_d = pc_q;
                    end else begin
                        instr_d    = imem_rdata;
                        instr_pc_d = pc_q;
                        valid_d    = 1'b1;
                        state_d    = HOLD;
                    end
                end else begin
                    state_d = FETCH;
                end
            end
            HOLD: begin
                if (load_bad_s) begin
                    state_d = FAULT;
                    mis_d   = 1'b1;
                    valid_d = 1'b0;
                end else if (load_ok_s) begin
                    pc_d    = next_pc;
                    addr_d  = next_pc;
                    valid_d = 1'b0;
                    state_d = FETCH;
                end else if (instr_ready) begin
                    valid_d = 1'b0;
                    state_d = WAIT_PC;
                end else begin
                    state_d = HOLD;
                end
            end
            WAIT_PC: begin
                if (load_bad_s) begin
                    state_d = FAULT;
                    mis_d   = 1'b1;
                end else if (load_ok_s) begin
                    pc_d    = next_pc;
                    addr_d  = next_pc;
                    state_d = FETCH;
                end else begin
                    state_d = WAIT_PC;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = FAULT;
                mis_d   = 1'b1;
                valid_d = 1'b0;
                kill_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            kill_q     <= 1'b0;
            instr_q    <= 32'h0000_0000;
            instr_pc_q <= 32'h0000_0000;
            valid_q    <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            kill_q     <= kill_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            mis_q      <= mis_d;
        end
    end

    assign imem_req    = (state_q == FETCH) && !rst;
    assign imem_addr   = addr_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;
    assign misaligned  = mis_q;

endmodule
